// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: digit/operation entry sequencer for a two-operand calculator.
// Collects four decimal digits (c1..c4), then an operation code. It then
// launches the datapath with a one-cycle alu_go pulse and waits for alu_done.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   digit_in/digit_stb    digit value with its one-cycle strobe
//   op_in/op_stb          operation code with its one-cycle strobe
//   clr                   abandon entry, zero the registers, return to E1
//   alu_done              datapath completion; only looked at in CALC
//   c1..c4, op            registered operand digits and operation code
//   alu_go                one-cycle datapath start pulse
//   done                  high while in DONE
//   err                   one-cycle pulse for every rejected strobe
//   state_o               current state encoding
// Every output comes straight from a flop.
module calc_entry_ctrl #(
  parameter logic [3:0] DIGIT_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_stb,
  input  logic [1:0] op_in,
  input  logic       op_stb,
  input  logic       clr,
  input  logic       alu_done,
  output logic [3:0] c1,
  output logic [3:0] c2,
  output logic [3:0] c3,
  output logic [3:0] c4,
  output logic [1:0] op,
  output logic       alu_go,
  output logic       done,
  output logic       err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_E1   = 3'd0,
    S_E2   = 3'd1,
    S_E3   = 3'd2,
    S_E4   = 3'd3,
    S_OPS  = 3'd4,
    S_CALC = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [1:0] op_q, op_d;
  logic       alu_go_q, alu_go_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       dig_ok;

  assign dig_ok = digit_stb && (digit_in <= DIGIT_MAX);

  always_comb begin
    state_d  = state_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    c3_d     = c3_q;
    c4_d     = c4_q;
    op_d     = op_q;
    alu_go_d = 1'b0;
    err_d    = 1'b0;
    if (clr) begin
      // clr beats every strobe and alu_done, and never raises err
      c1_d    = 4'd0;
      c2_d    = 4'd0;
      c3_d    = 4'd0;
      c4_d    = 4'd0;
      op_d    = 2'd0;
      state_d = S_E1;
    end else begin
      case (state_q)
        S_E1: if (dig_ok) begin c1_d = digit_in; state_d = S_E2; end
              else if (digit_stb || op_stb) err_d = 1'b1;
        S_E2: if (dig_ok) begin c2_d = digit_in; state_d = S_E3; end
              else if (digit_stb || op_stb) err_d = 1'b1;
        S_E3: if (dig_ok) begin c3_d = digit_in; state_d = S_E4; end
              else if (digit_stb || op_stb) err_d = 1'b1;
        S_E4: if (dig_ok) begin c4_d = digit_in; state_d = S_OPS; end
              else if (digit_stb || op_stb) err_d = 1'b1;
        S_OPS: begin
          // any digit here is out of place; a simultaneous op_stb still wins
          if (op_stb) begin
            op_d     = op_in;
            state_d  = S_CALC;
            alu_go_d = 1'b1;
          end else if (digit_stb) begin
            err_d = 1'b1;
          end
        end
        S_CALC: if (alu_done) state_d = S_DONE;  // strobes silently dropped
        S_DONE: begin
          // a fresh valid digit starts a new entry; otherwise an op repeats
          if (dig_ok) begin
            c1_d    = digit_in;
            c2_d    = 4'd0;
            c3_d    = 4'd0;
            c4_d    = 4'd0;
            state_d = S_E2;
          end else if (op_stb) begin
            op_d     = op_in;
            state_d  = S_CALC;
            alu_go_d = 1'b1;
          end else if (digit_stb) begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_E1;
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_E1;
      c1_q     <= 4'd0;
      c2_q     <= 4'd0;
      c3_q     <= 4'd0;
      c4_q     <= 4'd0;
      op_q     <= 2'd0;
      alu_go_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      c3_q     <= c3_d;
      c4_q     <= c4_d;
      op_q     <= op_d;
      alu_go_q <= alu_go_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign c1      = c1_q;
  assign c2      = c2_q;
  assign c3      = c3_q;
  assign c4      = c4_q;
  assign op      = op_q;
  assign alu_go  = alu_go_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus a randomized run that
// is checked every cycle against a behavioural model of the entry rules.
module tb_calc_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_stb = 1'b0;
  logic [1:0] op_in = 2'd0;
  logic       op_stb = 1'b0;
  logic       clr = 1'b0;
  logic       alu_done = 1'b0;
  logic [3:0] c1, c2, c3, c4;
  logic [1:0] op;
  logic       alu_go, done, err;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  // reference model state: phase 0..3 entering digit #phase, 4 waiting op,
  // 5 calculating, 6 done
  int       m_phase;
  int       m_dig[4];
  int       m_op;
  bit       m_go, m_done, m_err;

  calc_entry_ctrl #(.DIGIT_MAX(4'd9)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_stb(digit_stb),
    .op_in(op_in), .op_stb(op_stb), .clr(clr), .alu_done(alu_done),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .op(op), .alu_go(alu_go),
    .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic model_update(input bit ds, input int di, input bit os,
                              input int oi, input bit cl, input bit ad,
                              input bit rs);
    bit dig_legal, op_legal;
    dig_legal = ds && di <= 9 && (m_phase < 4 || m_phase == 6);
    op_legal  = os && (m_phase == 4 || m_phase == 6);
    m_go  = 0;
    m_err = 0;
    if (rs || cl) begin
      m_phase = 0;
      foreach (m_dig[i]) m_dig[i] = 0;
      m_op = 0;
    end else if (m_phase == 5) begin
      if (ad) m_phase = 6;
    end else if (dig_legal) begin
      if (m_phase == 6) begin
        foreach (m_dig[i]) m_dig[i] = 0;
        m_dig[0] = di;
        m_phase  = 1;
      end else begin
        m_dig[m_phase] = di;
        m_phase = m_phase + 1;
      end
    end else if (op_legal) begin
      m_op    = oi;
      m_phase = 5;
      m_go    = 1;
    end else if (ds || os) begin
      m_err = 1;
    end
    m_done = (m_phase == 6);
  endtask

  // Apply one cycle of inputs, keep the model in step, settle past the edge.
  task automatic tick(input bit ds, input int di, input bit os, input int oi,
                      input bit cl, input bit ad, input bit rs);
    digit_stb = ds; digit_in = 4'(di); op_stb = os; op_in = 2'(oi);
    clr = cl; alu_done = ad; rst = rs;
    @(posedge clk);
    model_update(ds, di, os, oi, cl, ad, rs);
    #1;
    digit_stb = 0; op_stb = 0; clr = 0; alu_done = 0; rst = 0;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    tick(1, a, 0, 0, 0, 0, 0);
    tick(1, b, 0, 0, 0, 0, 0);
    tick(1, c, 0, 0, 0, 0, 0);
    tick(1, d, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    tick(1, 5, 1, 3, 1, 1, 1);
    checks++;
    if ({state_o, c1, c2, c3, c4, op, alu_go, done, err} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want 000000",
               {state_o, c1, c2, c3, c4, op, alu_go, done, err});
    end
  endtask

  task automatic test_sequence();
    tick(0, 0, 0, 0, 0, 0, 1);
    enter(4, 2, 1, 7);
    checks++;
    if (state_o !== 3'd4) begin
      errors++; $display("FAIL seq_ops_state: got %0d want 4", state_o);
    end
    tick(0, 0, 1, 1, 0, 0, 0);
    checks++;
    if ({c1, c2, c3, c4} !== 16'h4217 || op !== 2'd1 || state_o !== 3'd5) begin
      errors++;
      $display("FAIL seq_calc: got c=%h op=%0d st=%0d want 4217 1 5",
               {c1, c2, c3, c4}, op, state_o);
    end
    checks++;
    if (alu_go !== 1'b1) begin
      errors++; $display("FAIL seq_go_high: got %b want 1", alu_go);
    end
    idle();
    checks++;
    if (alu_go !== 1'b0 || state_o !== 3'd5 || done !== 1'b0) begin
      errors++;
      $display("FAIL seq_go_pulse: go=%b st=%0d done=%b want 0 5 0",
               alu_go, state_o, done);
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (done !== 1'b1 || state_o !== 3'd6) begin
      errors++;
      $display("FAIL seq_done: done=%b st=%0d want 1 6", done, state_o);
    end
  endtask

  task automatic test_bad_digit();
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 3, 0, 0, 0, 0, 0);
    tick(1, 12, 0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || c2 !== 4'd0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL bad_digit: err=%b c2=%0d st=%0d want 1 0 1",
               err, c2, state_o);
    end
    idle();
    checks++;
    if (err !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL bad_digit_pulse: err=%b st=%0d want 0 1", err, state_o);
    end
  endtask

  task automatic test_clr();
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 2, 0, 0, 0, 0, 0);
    tick(1, 5, 0, 0, 1, 0, 0);
    checks++;
    if (state_o !== 3'd0 || {c1, c2, c3, c4} !== 16'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio: st=%0d c=%h err=%b want 0 0000 0",
               state_o, {c1, c2, c3, c4}, err);
    end
  endtask

  task automatic test_rst_calc();
    bit go_seen;
    tick(0, 0, 0, 0, 0, 0, 1);
    enter(1, 2, 3, 4);
    tick(0, 0, 1, 2, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (state_o !== 3'd0 || alu_go !== 1'b0) begin
      errors++;
      $display("FAIL rst_calc: st=%0d go=%b want 0 0", state_o, alu_go);
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    go_seen = alu_go;
    for (int i = 0; i < 4; i++) begin
      idle();
      go_seen |= alu_go;
    end
    checks++;
    if (state_o !== 3'd0 || done !== 1'b0 || go_seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_calc_late_done: st=%0d done=%b go=%b want 0 0 0",
               state_o, done, go_seen);
    end
  endtask

  task automatic test_done_reload();
    tick(0, 0, 0, 0, 0, 0, 1);
    enter(9, 9, 0, 1);
    tick(0, 0, 1, 3, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(1, 3, 0, 0, 0, 0, 0);
    checks++;
    if ({c1, c2, c3, c4} !== 16'h3000 || state_o !== 3'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_reload: c=%h st=%0d done=%b want 3000 1 0",
               {c1, c2, c3, c4}, state_o, done);
    end
  endtask

  task automatic test_simul();
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 6, 1, 2, 0, 0, 0);
    checks++;
    if (c1 !== 4'd6 || state_o !== 3'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL simul_strobes: c1=%0d st=%0d err=%b want 6 1 0",
               c1, state_o, err);
    end
  endtask

  task automatic test_random();
    logic [23:0] got, exp;
    tick(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 11),
           $urandom_range(0, 9) < 3, $urandom_range(0, 3),
           $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) == 0);
      got = {state_o, c1, c2, c3, c4, op, alu_go, done, err};
      exp = {3'(m_phase), 4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]),
             4'(m_dig[3]), 2'(m_op), m_go, m_done, m_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h want %h", n, got, exp);
      end
    end
  endtask

  initial begin
    m_phase = 0; m_op = 0; m_go = 0; m_done = 0; m_err = 0;
    foreach (m_dig[i]) m_dig[i] = 0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_bad_digit();
    test_clr();
    test_rst_calc();
    test_done_reload();
    test_simul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
